// File: rtl/mcu_spi_link.sv
// SPI mode-0 slave: oversamples the MCU pins in clk, decodes a target-select byte,
// then streams payload bytes to one of four targets and shifts their replies back.
module mcu_spi_link #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] data_in,
  output logic       data_in_start,
  output logic [3:0] tgt_strobe,
  input  logic [7:0] sys_dout,
  input  logic [7:0] hid_dout,
  input  logic [7:0] osd_dout,
  input  logic [7:0] sdc_dout
);

  typedef enum logic [1:0] {
    IDLE,
    TARGET,
    PAYLOAD
  } state_t;

  logic [SYNC_STAGES-1:0] csn_sync_q, sck_sync_q, mosi_sync_q;
  logic                   csn_prev_q, sck_prev_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [1:0] tgt_q, tgt_d;
  logic       tgt_valid_q, tgt_valid_d;
  logic       first_q, first_d;
  logic       load_pend_q, load_pend_d;
  logic [7:0] data_in_q, data_in_d;
  logic       start_q, start_d;
  logic [3:0] strobe_q, strobe_d;

  logic       csn_s, sck_s, mosi_s;
  logic       sck_rise, sck_fall, csn_fall;
  logic [7:0] rx_byte;
  logic [7:0] reply;

  // Sync chains reset low with csn_prev low, so a CSN already held low across
  // reset never looks like a falling edge: the frame must restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      csn_sync_q  <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      csn_prev_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csn_fall = ~csn_s & csn_prev_q;
  assign rx_byte  = {rx_q[6:0], mosi_s};

  always_comb begin
    reply = 8'h00;
    if (tgt_valid_q) begin
      case (tgt_q)
        2'd0:    reply = sys_dout;
        2'd1:    reply = hid_dout;
        2'd2:    reply = osd_dout;
        default: reply = sdc_dout;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    tgt_d       = tgt_q;
    tgt_valid_d = tgt_valid_q;
    first_d     = first_q;
    load_pend_d = load_pend_q;
    data_in_d   = data_in_q;
    start_d     = start_q;
    strobe_d    = '0;

    case (state_q)
      IDLE: begin
        bit_cnt_d   = '0;
        rx_d        = '0;
        tx_d        = '0;
        load_pend_d = 1'b0;
        if (csn_fall) state_d = TARGET;
      end

      TARGET: begin
        tx_d        = '0;
        load_pend_d = 1'b0;
        if (sck_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            tgt_d       = rx_byte[1:0];
            tgt_valid_d = (rx_byte[7:2] == 6'd0);
            first_d     = 1'b1;
            state_d     = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (sck_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_in_d   = rx_byte;
            start_d     = first_q;
            first_d     = 1'b0;
            load_pend_d = 1'b1;
            if (tgt_valid_q) strobe_d[tgt_q] = 1'b1;
          end
        end else if (sck_fall) begin
          if (load_pend_q) begin
            tx_d        = reply;
            load_pend_d = 1'b0;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // CSN high overrides everything, including a byte completing in the same clk.
    if (csn_s) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      rx_d        = '0;
      tx_d        = '0;
      tgt_valid_d = 1'b0;
      load_pend_d = 1'b0;
      data_in_d   = data_in_q;
      start_d     = start_q;
      strobe_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      tgt_q       <= '0;
      tgt_valid_q <= 1'b0;
      first_q     <= 1'b0;
      load_pend_q <= 1'b0;
      data_in_q   <= '0;
      start_q     <= 1'b0;
      strobe_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      tgt_q       <= tgt_d;
      tgt_valid_q <= tgt_valid_d;
      first_q     <= first_d;
      load_pend_q <= load_pend_d;
      data_in_q   <= data_in_d;
      start_q     <= start_d;
      strobe_q    <= strobe_d;
    end
  end

  assign spi_miso      = tx_q[7] & ~csn_s;
  assign data_in       = data_in_q;
  assign data_in_start = start_q;
  assign tgt_strobe    = strobe_q;

endmodule
